// File: rtl/dcache_write_buffer.sv
// Line write buffer between the L1 dcache controller and Data_Memory.
// Write-backs are queued in a circular FIFO and drained in the background; reads are served from the buffer when they hit.
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_enable_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LINE_W-1:0] req_data_i,
  output logic              req_ack_o,
  output logic [LINE_W-1:0] req_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LA_W  = ADDR_W - 5;

  typedef enum logic [1:0] {IDLE = 2'd0, WR_MEM = 2'd1, RD_MEM = 2'd2, RESP = 2'd3} state_t;

  logic [LA_W-1:0]   line_addr_r [DEPTH];
  logic [LINE_W-1:0] line_data_r [DEPTH];
  logic [PTR_W-1:0]  head_r, tail_r;
  logic [CNT_W-1:0]  count_r, count_n;
  state_t            state_r, state_n;

  logic              req_ack_r, req_ack_n;
  logic [LINE_W-1:0] req_data_r, req_data_n;
  logic              mem_enable_r, mem_enable_n;
  logic              mem_write_r, mem_write_n;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_n;
  logic [LINE_W-1:0] mem_data_r, mem_data_n;
  logic              empty_r, empty_n;

  logic [LA_W-1:0]   req_line_s;
  logic              hit_s;
  logic [PTR_W-1:0]  hit_idx_s;
  logic [PTR_W-1:0]  idx_v;
  logic              match_v;
  logic              wr_req_s, rd_req_s, wr_window_s;
  logic              push_s, pop_s, coalesce_s, accept_wr_s;
  logic [4:0]        unused_addr_s;

  assign req_line_s    = req_addr_i[ADDR_W-1:5];
  assign unused_addr_s = req_addr_i[4:0];

  // Youngest valid entry matching the request line; the in-flight head is never a candidate.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {PTR_W{1'b0}};
    idx_v     = head_r;
    match_v   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_v     = head_r + PTR_W'(k);
      match_v   = (CNT_W'(k) < count_r) && (line_addr_r[idx_v] == req_line_s) &&
                  !((state_r == WR_MEM) && (k == 0));
      hit_idx_s = match_v ? idx_v : hit_idx_s;
      hit_s     = hit_s | match_v;
    end
  end

  // Request acceptance, downstream FSM and next values of all registered outputs.
  always_comb begin
    wr_req_s     = req_enable_i & req_write_i & ~req_ack_r;
    rd_req_s     = req_enable_i & ~req_write_i & ~req_ack_r;
    wr_window_s  = (state_r == IDLE) || (state_r == WR_MEM);
    pop_s        = (state_r == WR_MEM) & mem_ack_i;
    coalesce_s   = wr_req_s & wr_window_s & hit_s;
    push_s       = wr_req_s & wr_window_s & ~hit_s & ((count_r < CNT_W'(DEPTH)) | pop_s);
    accept_wr_s  = coalesce_s | push_s;
    state_n      = state_r;
    req_ack_n    = accept_wr_s;
    req_data_n   = req_data_r;
    mem_enable_n = mem_enable_r;
    mem_write_n  = mem_write_r;
    mem_addr_n   = mem_addr_r;
    mem_data_n   = mem_data_r;
    case (state_r)
      IDLE: begin
        if (rd_req_s && hit_s) begin
          req_ack_n  = 1'b1;
          req_data_n = line_data_r[hit_idx_s];
        end else if (rd_req_s) begin
          state_n      = RD_MEM;
          mem_enable_n = 1'b1;
          mem_write_n  = 1'b0;
          mem_addr_n   = {req_line_s, 5'b00000};
          mem_data_n   = {LINE_W{1'b0}};
        end else if ((count_r != {CNT_W{1'b0}}) && !accept_wr_s) begin
          // Holding off the drain while a write lands keeps the head snapshot coherent.
          state_n      = WR_MEM;
          mem_enable_n = 1'b1;
          mem_write_n  = 1'b1;
          mem_addr_n   = {line_addr_r[head_r], 5'b00000};
          mem_data_n   = line_data_r[head_r];
        end else begin
          state_n = IDLE;
        end
      end
      WR_MEM: begin
        if (mem_ack_i) begin
          state_n      = IDLE;
          mem_enable_n = 1'b0;
          mem_write_n  = 1'b0;
        end else begin
          state_n = WR_MEM;
        end
      end
      RD_MEM: begin
        if (mem_ack_i) begin
          state_n      = RESP;
          mem_enable_n = 1'b0;
          req_ack_n    = 1'b1;
          req_data_n   = mem_data_i;
        end else begin
          state_n = RD_MEM;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n      = IDLE;
        mem_enable_n = 1'b0;
        mem_write_n  = 1'b0;
      end
    endcase
    count_n = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    empty_n = (count_n == {CNT_W{1'b0}}) && (state_n != WR_MEM);
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= IDLE;
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      req_ack_r    <= 1'b0;
      req_data_r   <= {LINE_W{1'b0}};
      mem_enable_r <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_data_r   <= {LINE_W{1'b0}};
      empty_r      <= 1'b1;
    end else begin
      state_r      <= state_n;
      head_r       <= head_r + PTR_W'(pop_s);
      tail_r       <= tail_r + PTR_W'(push_s);
      count_r      <= count_n;
      req_ack_r    <= req_ack_n;
      req_data_r   <= req_data_n;
      mem_enable_r <= mem_enable_n;
      mem_write_r  <= mem_write_n;
      mem_addr_r   <= mem_addr_n;
      mem_data_r   <= mem_data_n;
      empty_r      <= empty_n;
    end
  end

  // Line storage: enqueue at tail or overwrite a coalescing entry.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      line_addr_r[tail_r] <= req_line_s;
      line_data_r[tail_r] <= req_data_i;
    end else if (coalesce_s) begin
      line_data_r[hit_idx_s] <= req_data_i;
    end
  end

  assign req_ack_o    = req_ack_r;
  assign req_data_o   = req_data_r;
  assign mem_enable_o = mem_enable_r;
  assign mem_write_o  = mem_write_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_data_o   = mem_data_r;
  assign empty_o      = empty_r;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer with a latency-programmable Data_Memory responder.
module tb_dcache_write_buffer;

  logic         clk_i;
  logic         rst_i;
  logic         req_enable_i;
  logic         req_write_i;
  logic [31:0]  req_addr_i;
  logic [255:0] req_data_i;
  logic         req_ack_o;
  logic [255:0] req_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;
  logic         empty_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int lat_cnt = 0;
  int mem_ack_cyc = 0;

  logic [255:0] mem_model [64];
  logic         log_wr [$];
  logic [31:0]  log_addr [$];
  logic [255:0] log_data [$];

  dcache_write_buffer #(.DEPTH(4), .LINE_W(256), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_enable_i(req_enable_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ack_o(req_ack_o), .req_data_o(req_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .empty_o(empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Data_Memory responder: acks after mem_lat cycles of enable and logs every transaction.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      mem_ack_i = 1'b0;
      lat_cnt = 0;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      lat_cnt = 0;
      chk("mem_gap", {255'b0, mem_enable_o}, 256'b0);
    end else if (mem_enable_o) begin
      if (lat_cnt >= mem_lat - 1) begin
        mem_ack_i = 1'b1;
        mem_ack_cyc = cyc + 1;
        lat_cnt = 0;
        log_wr.push_back(mem_write_o);
        log_addr.push_back(mem_addr_o);
        log_data.push_back(mem_data_o);
        if (mem_write_o) mem_model[mem_addr_o[10:5]] = mem_data_o;
        else mem_data_i = mem_model[mem_addr_o[10:5]];
      end else begin
        lat_cnt = lat_cnt + 1;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  task automatic clear_log();
    log_wr.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                        output int n, output int at, output logic [255:0] rd);
    req_enable_i = 1'b1;
    req_write_i  = wr;
    req_addr_i   = a;
    req_data_i   = d;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n = n + 1;
    end while (!req_ack_o && n < 300);
    at = cyc;
    rd = req_data_o;
    chk("req_ack_timeout", {255'b0, req_ack_o}, 256'b1);
    req_enable_i = 1'b0;
    req_write_i  = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    do begin
      @(posedge clk_i); #1;
      k = k + 1;
    end while (!(empty_o && !mem_enable_o) && k < 400);
    chk("empty_wait", {255'b0, empty_o}, 256'b1);
  endtask

  int n;
  int at;
  int exp_at;
  logic [255:0] rd;
  logic [255:0] a5;

  initial begin
    rst_i = 1'b0;
    req_enable_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i = 32'h0;
    req_data_i = 256'h0;
    mem_ack_i = 1'b0;
    mem_data_i = 256'h0;
    for (int i = 0; i < 64; i++) mem_model[i] = 256'h0;
    a5 = {32{8'hA5}};
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req_ack", {255'b0, req_ack_o}, 256'b0);
    chk("rst_req_data", req_data_o, 256'h0);
    chk("rst_mem_en", {255'b0, mem_enable_o}, 256'b0);
    chk("rst_mem_addr", {224'b0, mem_addr_o}, 256'h0);
    chk("rst_empty", {255'b0, empty_o}, 256'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // single write-back drains to line 32
    mem_lat = 1;
    clear_log();
    do_req(1'b1, 32'h400, a5, n, at, rd);
    chk("t1_lat", n, 1);
    chk("t1_not_empty", {255'b0, empty_o}, 256'b0);
    wait_empty();
    chk("t1_nops", log_wr.size(), 1);
    chk("t1_addr", {224'b0, log_addr[0]}, 256'h400);
    chk("t1_wr", {255'b0, log_wr[0]}, 256'b1);
    chk("t1_mem", mem_model[32], a5);

    // fill the buffer, fifth write stalls for the first drain
    mem_lat = 10;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 32'(i * 32), {8{32'(i + 1)}}, n, at, rd);
      chk("t2_lat", n, 1);
    end
    do_req(1'b1, 32'h080, {8{32'h5}}, n, at, rd);
    chk("t2_stalled", {255'b0, (n > 1)}, 256'b1);
    chk("t2_ack_at_drain", at, mem_ack_cyc);
    wait_empty();
    chk("t2_nops", log_wr.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_order", {224'b0, log_addr[i]}, 256'(i * 32));
    chk("t2_last_data", log_data[4], {8{32'h5}});

    // read hit on a buffered line, no memory read
    mem_lat = 20;
    clear_log();
    do_req(1'b1, 32'h300, {8{32'hDEAD}}, n, at, rd);
    do_req(1'b1, 32'h020, 256'h11, n, at, rd);
    chk("t3_wr_lat", n, 1);
    do_req(1'b0, 32'h020, 256'h0, n, at, rd);
    exp_at = mem_ack_cyc + 1;
    chk("t3_rd_data", rd, 256'h11);
    chk("t3_rd_at", at, exp_at);
    wait_empty();
    chk("t3_nops", log_wr.size(), 2);
    chk("t3_no_read", {255'b0, log_wr[0] & log_wr[1]}, 256'b1);

    // coalescing two writes to one line
    clear_log();
    do_req(1'b1, 32'h200, {8{32'hBEEF}}, n, at, rd);
    do_req(1'b1, 32'h040, 256'h1, n, at, rd);
    chk("t4_lat1", n, 1);
    do_req(1'b1, 32'h040, 256'h2, n, at, rd);
    chk("t4_lat2", n, 1);
    wait_empty();
    chk("t4_nops", log_wr.size(), 2);
    chk("t4_addr", {224'b0, log_addr[1]}, 256'h040);
    chk("t4_data", log_data[1], 256'h2);

    // read miss jumps ahead of buffered drains
    mem_lat = 8;
    clear_log();
    mem_model[0] = 256'h5;
    do_req(1'b1, 32'h100, {8{32'hCAFE}}, n, at, rd);
    do_req(1'b1, 32'h0A0, 256'hA, n, at, rd);
    do_req(1'b1, 32'h0C0, 256'hB, n, at, rd);
    do_req(1'b0, 32'h000, 256'h0, n, at, rd);
    chk("t5_rd_data", rd, 256'h5);
    chk("t5_rd_at", at, mem_ack_cyc);
    wait_empty();
    chk("t5_nops", log_wr.size(), 4);
    chk("t5_rd_kind", {255'b0, log_wr[1]}, 256'b0);
    chk("t5_rd_addr", {224'b0, log_addr[1]}, 256'h0);
    chk("t5_drain1", {224'b0, log_addr[2]}, 256'h0A0);
    chk("t5_drain2", {224'b0, log_addr[3]}, 256'h0C0);

    // asynchronous reset in the middle of a drain
    mem_lat = 50;
    clear_log();
    do_req(1'b1, 32'h1E0, {8{32'h77}}, n, at, rd);
    chk("t6_in_flight", {255'b0, mem_enable_o}, 256'b1);
    rst_i = 1'b0;
    #2;
    chk("t6_mem_en", {255'b0, mem_enable_o}, 256'b0);
    chk("t6_mem_wr", {255'b0, mem_write_o}, 256'b0);
    chk("t6_mem_addr", {224'b0, mem_addr_o}, 256'h0);
    chk("t6_mem_data", mem_data_o, 256'h0);
    chk("t6_req_ack", {255'b0, req_ack_o}, 256'b0);
    chk("t6_empty", {255'b0, empty_o}, 256'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    mem_lat = 2;
    clear_log();
    do_req(1'b1, 32'h220, {8{32'h99}}, n, at, rd);
    chk("t6_post_lat", n, 1);
    wait_empty();
    chk("t6_nops", log_wr.size(), 1);
    chk("t6_addr", {224'b0, log_addr[0]}, 256'h220);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
